// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches and buffers words in a FIFO.
// Define IF_FETCH_STALL_CNT_EN to add stall_cnt_o, a saturating count of cycles with no valid instruction.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
`ifdef IF_FETCH_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_nxt;
    logic [31:0]      req_addr;
    logic [31:0]      jump_target;
    logic [31:0]      fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             fire;
    logic             push;
    logic             pop;
    logic             req_nxt;

    assign jump_target = jump_addr_i & 32'hFFFF_FFFC;
    assign fire        = ibus_req_o && ibus_gnt_i;
    assign push        = (state == WAIT) && ibus_rvalid_i && !jump_en_i;
    assign pop         = (count != '0) && !hold_flag_i && !jump_en_i;

    // A request granted in the jump cycle, or still in flight at a jump, must have its response dropped.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (fire) state_nxt = jump_en_i ? DISCARD : WAIT;
            WAIT:    begin
                if (ibus_rvalid_i)  state_nxt = REQ;
                else if (jump_en_i) state_nxt = DISCARD;
            end
            DISCARD: if (ibus_rvalid_i) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase

        if (jump_en_i)  fetch_pc_nxt = jump_target;
        else if (fire)  fetch_pc_nxt = fetch_pc + 32'd4;

        if (jump_en_i)          count_nxt = '0;
        else if (push && !pop)  count_nxt = count + 1'b1;
        else if (pop && !push)  count_nxt = count - 1'b1;

        // Nothing is outstanding in REQ, so credit reduces to free FIFO slots.
        req_nxt = (state_nxt == REQ) && (count_nxt < DEPTH_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            ibus_req_o <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            ibus_req_o <= req_nxt;
            count      <= count_nxt;
            if (fire) req_addr <= fetch_pc;
            if (jump_en_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_addr[wr_ptr] <= req_addr;
                    fifo_data[wr_ptr] <= ibus_rdata_i;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign ibus_addr_o  = fetch_pc;
    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? fifo_data[rd_ptr] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr] : 32'h0000_0000;

`ifdef IF_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (!inst_valid_o && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a bus memory model plus an address-stream model of what must be fetched and delivered.
// Directed scenarios pin reset, sequential fetch, hold, jump-in-flight, jump+hold and PC wrap-around.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef IF_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic        gnt_en;
    int          mem_latency;
    logic        pending;
    int          countdown;
    logic [31:0] pend_addr;
    logic [31:0] exp_fetch;
    logic [31:0] exp_next;
    logic [31:0] grant_log [$];
    logic [31:0] empty_obs = 32'd0;
    logic        found;

    if_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INST  (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
`ifdef IF_FETCH_STALL_CNT_EN
        .stall_cnt_o  (stall_cnt),
`endif
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic jump, input logic [31:0] target, input logic hold);
        jump_en_i   = jump;
        jump_addr_i = target;
        hold_flag_i = hold;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inst_valid_o) break;
            tick;
        end
        if (!inst_valid_o) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Memory and checker share the falling edge so the model sees each grant it issues.
    initial begin
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'd0;
        pending       = 1'b0;
        countdown     = 0;
        pend_addr     = 32'd0;
        exp_fetch     = RESET_PC;
        exp_next      = RESET_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                ibus_gnt_i    = 1'b0;
                ibus_rvalid_i = 1'b0;
                pending       = 1'b0;
                exp_fetch     = RESET_PC;
                exp_next      = RESET_PC;
            end else begin
                ibus_rvalid_i = 1'b0;
                if (pending) begin
                    countdown--;
                    if (countdown <= 0) begin
                        ibus_rvalid_i = 1'b1;
                        ibus_rdata_i  = pend_addr ^ KEY;
                        pending       = 1'b0;
                    end
                end
                ibus_gnt_i = 1'b0;
                if (ibus_req_o && gnt_en && !pending) begin
                    ibus_gnt_i = 1'b1;
                    pending    = 1'b1;
                    pend_addr  = ibus_addr_o;
                    countdown  = mem_latency;
                end

                if (ibus_req_o)
                    checkOutput("credit", 32'((exp_fetch - exp_next) < 32'(4 * DEPTH)), 32'd1);
                if (ibus_gnt_i) begin
                    checkOutput("fetch_addr", ibus_addr_o, exp_fetch);
                    grant_log.push_back(ibus_addr_o);
                    exp_fetch += 32'd4;
                end
                if (inst_valid_o) begin
                    checkOutput("head_addr", inst_addr_o, exp_next);
                    checkOutput("head_data", inst_o, exp_next ^ KEY);
                end else begin
                    checkOutput("empty_inst", inst_o, NOP);
                    checkOutput("empty_addr", inst_addr_o, 32'd0);
                end
`ifdef IF_FETCH_STALL_CNT_EN
                checkOutput("stall_cnt", stall_cnt, empty_obs);
                if (!inst_valid_o) empty_obs++;
`endif
                if (jump_en_i) begin
                    exp_fetch = jump_addr_i & 32'hFFFF_FFFC;
                    exp_next  = exp_fetch;
                end else if (inst_valid_o && !hold_flag_i) begin
                    exp_next += 32'd4;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        gnt_en      = 1'b0;
        mem_latency = 1;
        found       = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);

        $display("[TB] reset and first request");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req", ibus_req_o, 32'd0);
        checkOutput("rst_valid", inst_valid_o, 32'd0);
        checkOutput("rst_inst", inst_o, 32'h0000_0013);
        checkOutput("rst_inst_addr", inst_addr_o, 32'd0);
        checkOutput("rst_bus_addr", ibus_addr_o, 32'h8000_0000);
`ifdef IF_FETCH_STALL_CNT_EN
        checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        checkOutput("idle_req", ibus_req_o, 32'd0);
        tick;
        checkOutput("first_req", ibus_req_o, 32'd1);
        checkOutput("first_addr", ibus_addr_o, 32'h8000_0000);

        $display("[TB] sequential fetch from 0x0");
        applyStimulus(1'b1, 32'h0000_0000, 1'b0);
        tick;
        applyStimulus(1'b0, 32'd0, 1'b0);
        gnt_en = 1'b1;
        tick;
        tick;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("seq_valid%0d", i), 32'(i % 2 == 0), 32'(inst_valid_o));
            if (i % 2 == 0) begin
                checkOutput($sformatf("seq_addr%0d", i), inst_addr_o, 32'(4 * (i / 2)));
                checkOutput($sformatf("seq_data%0d", i), inst_o, 32'(4 * (i / 2)) ^ KEY);
            end
            tick;
        end

        $display("[TB] hold with FIFO filling");
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        tick;
        applyStimulus(1'b0, 32'd0, 1'b1);
        repeat (5) tick;
        for (int i = 0; i < 2; i++) begin
            checkOutput("hold_req", ibus_req_o, 32'd0);
            checkOutput("hold_valid", inst_valid_o, 32'd1);
            checkOutput("hold_head_addr", inst_addr_o, 32'h0000_0000);
            checkOutput("hold_head_data", inst_o, 32'h0000_0000 ^ KEY);
            tick;
        end
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("release_addr0", inst_addr_o, 32'h0000_0000);
        tick;
        checkOutput("release_valid1", inst_valid_o, 32'd1);
        checkOutput("release_addr1", inst_addr_o, 32'h0000_0004);

        $display("[TB] jump while a slow response is in flight");
        mem_latency = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ibus_gnt_i) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t4_grant_seen", 32'(found), 32'd1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        tick;
        applyStimulus(1'b0, 32'd0, 1'b0);
        mem_latency = 1;
        checkOutput("t4_discard_req0", ibus_req_o, 32'd0);
        tick;
        checkOutput("t4_discard_req1", ibus_req_o, 32'd0);
        tick;
        checkOutput("t4_req", ibus_req_o, 32'd1);
        checkOutput("t4_req_addr", ibus_addr_o, 32'h0000_0100);
        waitValid("t4_valid", 10);
        checkOutput("t4_first_addr", inst_addr_o, 32'h0000_0100);

        $display("[TB] jump and hold together with full FIFO");
        applyStimulus(1'b0, 32'd0, 1'b1);
        repeat (8) tick;
        checkOutput("t5_full_req", ibus_req_o, 32'd0);
        checkOutput("t5_full_head", inst_addr_o, 32'h0000_0100);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        tick;
        checkOutput("t5_flushed", inst_valid_o, 32'd0);
        checkOutput("t5_req", ibus_req_o, 32'd1);
        checkOutput("t5_req_addr", ibus_addr_o, 32'h0000_0200);
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitValid("t5_valid", 10);
        checkOutput("t5_first_addr", inst_addr_o, 32'h0000_0200);

        $display("[TB] PC wrap-around");
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        tick;
        grant_log.delete();
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitValid("t6_valid0", 10);
        checkOutput("t6_addr0", inst_addr_o, 32'hFFFF_FFFC);
        tick;
        waitValid("t6_valid1", 10);
        checkOutput("t6_addr1", inst_addr_o, 32'h0000_0000);
        checkOutput("t6_grant_count", 32'(grant_log.size() >= 2), 32'd1);
        if (grant_log.size() >= 2) begin
            checkOutput("t6_grant0", grant_log[0], 32'hFFFF_FFFC);
            checkOutput("t6_grant1", grant_log[1], 32'h0000_0000);
        end
`ifdef IF_FETCH_STALL_CNT_EN
        checkOutput("t6_stall_cnt", stall_cnt, empty_obs);
`endif
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
